// File: rtl/mc_controller_if.sv
// Control bundle between the multicycle controller and its datapath/memory.
// The master side is the controller; the slave side is the datapath and memory environment.
interface mc_controller_if;
  logic [31:0] instruction;
  logic        mem_ready;
  logic        PcWrite;
  logic        PcWriteCond;
  logic        IorD;
  logic        MemRead;
  logic        MemWrite;
  logic        IrWrite;
  logic        MemtToReg;
  logic        RegDst;
  logic        regWrite;
  logic        AluSrcA;
  logic [1:0]  AluSrcB;
  logic [1:0]  AluOp;
  logic [1:0]  PcSource;
  logic [1:0]  ImmOp;
  logic [3:0]  state;
  logic        illegal;
  logic        timeout;

  modport master (
    input  instruction, mem_ready,
    output PcWrite, PcWriteCond, IorD, MemRead, MemWrite, IrWrite,
           MemtToReg, RegDst, regWrite, AluSrcA, AluSrcB, AluOp,
           PcSource, ImmOp, state, illegal, timeout
  );

  modport slave (
    output instruction, mem_ready,
    input  PcWrite, PcWriteCond, IorD, MemRead, MemWrite, IrWrite,
           MemtToReg, RegDst, regWrite, AluSrcA, AluSrcB, AluOp,
           PcSource, ImmOp, state, illegal, timeout
  );
endinterface

// File: rtl/mc_controller.sv
// Multicycle CPU control FSM with memory wait-state timeout and sticky trap flags.
// All strobes are forced low combinationally while reset is asserted.
//
// state  | meaning
// FETCH  | read instruction, PC+4 (PC/IR written on mem_ready)
// DECODE | read registers, compute branch target
// MEMADR | compute load/store address
// MEMRD  | data memory read, wait for mem_ready
// MEMWB  | write load data to rt
// MEMWR  | data memory write, wait for mem_ready
// EXEC   | R-type ALU operation
// RWB    | write ALU result to rd
// BRANCH | compare and conditionally update PC
// JUMP   | load jump target into PC
// IEXEC  | immediate ALU operation
// IWB    | write immediate result to rt
// TRAP   | halted on illegal opcode or memory timeout
module mc_controller #(
  parameter int TIMEOUT      = 15,
  parameter bit ILLEGAL_TRAP = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  mc_controller_if.master bus
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    RWB    = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    IEXEC  = 4'd10,
    IWB    = 4'd11,
    TRAP   = 4'd12
  } stateType;

  localparam logic [7:0] TO_LAST = (TIMEOUT > 0) ? 8'(TIMEOUT - 1) : 8'd0;

  stateType   curState, nextState;
  logic [7:0] waitCnt;
  logic       illegalFlag, timeoutFlag;
  logic       setIllegal, setTimeout;
  logic       waitState, toHit;
  logic [5:0] opcode;

  logic       pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
  logic       memtToReg, regDst, regWr, aluSrcA;
  logic [1:0] aluSrcB, aluOp, pcSource, immOp;

  assign opcode    = bus.instruction[31:26];
  assign waitState = (curState == FETCH) || (curState == MEMRD) || (curState == MEMWR);
  // mem_ready is excluded here so that a completing access always wins over the timeout
  assign toHit     = (TIMEOUT != 0) && (waitCnt == TO_LAST) && !bus.mem_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      curState    <= FETCH;
      waitCnt     <= 8'd0;
      illegalFlag <= 1'b0;
      timeoutFlag <= 1'b0;
    end else begin
      curState    <= nextState;
      illegalFlag <= illegalFlag | setIllegal;
      timeoutFlag <= timeoutFlag | setTimeout;
      if (nextState != curState)
        waitCnt <= 8'd0;
      else if (waitState && !bus.mem_ready && waitCnt != 8'hFF)
        waitCnt <= waitCnt + 8'd1;
    end
  end

  always_comb begin
    nextState   = curState;
    setIllegal  = 1'b0;
    setTimeout  = 1'b0;
    pcWrite     = 1'b0;
    pcWriteCond = 1'b0;
    iorD        = 1'b0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    irWrite     = 1'b0;
    memtToReg   = 1'b0;
    regDst      = 1'b0;
    regWr       = 1'b0;
    aluSrcA     = 1'b0;
    aluSrcB     = 2'b00;
    aluOp       = 2'b00;
    pcSource    = 2'b00;
    immOp       = 2'b00;

    unique case (curState)
      FETCH: begin
        memRead = 1'b1;
        aluSrcB = 2'b01;
        pcWrite = bus.mem_ready;
        irWrite = bus.mem_ready;
        if (bus.mem_ready)
          nextState = DECODE;
        else if (toHit) begin
          nextState  = TRAP;
          setTimeout = 1'b1;
        end
      end
      DECODE: begin
        aluSrcB = 2'b11;
        case (opcode)
          6'b000000:            nextState = EXEC;
          6'b100011, 6'b101011: nextState = MEMADR;
          6'b000100:            nextState = BRANCH;
          6'b000010:            nextState = JUMP;
          6'b001000, 6'b001100, 6'b001101: nextState = IEXEC;
          default: begin
            if (ILLEGAL_TRAP) begin
              nextState  = TRAP;
              setIllegal = 1'b1;
            end else begin
              nextState = FETCH;
            end
          end
        endcase
      end
      MEMADR: begin
        aluSrcA   = 1'b1;
        aluSrcB   = 2'b10;
        nextState = (opcode == 6'b100011) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        memRead = 1'b1;
        iorD    = 1'b1;
        if (bus.mem_ready)
          nextState = MEMWB;
        else if (toHit) begin
          nextState  = TRAP;
          setTimeout = 1'b1;
        end
      end
      MEMWB: begin
        memtToReg = 1'b1;
        regWr     = 1'b1;
        nextState = FETCH;
      end
      MEMWR: begin
        memWrite = 1'b1;
        iorD     = 1'b1;
        if (bus.mem_ready)
          nextState = FETCH;
        else if (toHit) begin
          nextState  = TRAP;
          setTimeout = 1'b1;
        end
      end
      EXEC: begin
        aluSrcA   = 1'b1;
        aluOp     = 2'b10;
        nextState = RWB;
      end
      RWB: begin
        regDst    = 1'b1;
        regWr     = 1'b1;
        nextState = FETCH;
      end
      BRANCH: begin
        aluSrcA     = 1'b1;
        aluOp       = 2'b01;
        pcWriteCond = 1'b1;
        pcSource    = 2'b01;
        nextState   = FETCH;
      end
      JUMP: begin
        pcWrite   = 1'b1;
        pcSource  = 2'b10;
        nextState = FETCH;
      end
      IEXEC, IWB: begin
        case (opcode)
          6'b001100: immOp = 2'b01;
          6'b001101: immOp = 2'b10;
          default:   immOp = 2'b00;
        endcase
        if (curState == IEXEC) begin
          aluSrcA   = 1'b1;
          aluSrcB   = 2'b10;
          aluOp     = 2'b11;
          nextState = IWB;
        end else begin
          regWr     = 1'b1;
          nextState = FETCH;
        end
      end
      TRAP:    nextState = TRAP;
      default: nextState = FETCH;
    endcase
  end

  assign bus.PcWrite     = reset & pcWrite;
  assign bus.PcWriteCond = reset & pcWriteCond;
  assign bus.IorD        = reset & iorD;
  assign bus.MemRead     = reset & memRead;
  assign bus.MemWrite    = reset & memWrite;
  assign bus.IrWrite     = reset & irWrite;
  assign bus.MemtToReg   = reset & memtToReg;
  assign bus.RegDst      = reset & regDst;
  assign bus.regWrite    = reset & regWr;
  assign bus.AluSrcA     = reset & aluSrcA;
  assign bus.AluSrcB     = reset ? aluSrcB  : 2'b00;
  assign bus.AluOp       = reset ? aluOp    : 2'b00;
  assign bus.PcSource    = reset ? pcSource : 2'b00;
  assign bus.ImmOp       = reset ? immOp    : 2'b00;
  assign bus.state       = curState;
  assign bus.illegal     = illegalFlag;
  assign bus.timeout     = timeoutFlag;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: per-cycle vector table plus reset, trap and timeout sequences.
module tb_mc_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] instr = 32'd0;
  logic        memReady = 1'b0;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  mc_controller_if bus0 ();
  mc_controller_if bus1 ();
  mc_controller_if bus2 ();

  assign bus0.instruction = instr;
  assign bus0.mem_ready   = memReady;
  assign bus1.instruction = instr;
  assign bus1.mem_ready   = memReady;
  assign bus2.instruction = instr;
  assign bus2.mem_ready   = memReady;

  mc_controller dut (.clk(clk), .reset(reset), .bus(bus0));
  mc_controller #(.TIMEOUT(15), .ILLEGAL_TRAP(1'b0)) dutNoTrap (.clk(clk), .reset(reset), .bus(bus1));
  mc_controller #(.TIMEOUT(0), .ILLEGAL_TRAP(1'b1)) dutNoTo (.clk(clk), .reset(reset), .bus(bus2));

  // {PcWrite,PcWriteCond,IorD,MemRead,MemWrite,IrWrite,MemtToReg,RegDst,regWrite,AluSrcA,AluSrcB,AluOp,PcSource,ImmOp}
  logic [17:0] outs0;
  assign outs0 = {bus0.PcWrite, bus0.PcWriteCond, bus0.IorD, bus0.MemRead, bus0.MemWrite,
                  bus0.IrWrite, bus0.MemtToReg, bus0.RegDst, bus0.regWrite, bus0.AluSrcA,
                  bus0.AluSrcB, bus0.AluOp, bus0.PcSource, bus0.ImmOp};

  localparam logic [17:0] O_ZERO    = 18'b0_0_0_0_0_0_0_0_0_0_00_00_00_00;
  localparam logic [17:0] O_FETCH_W = 18'b0_0_0_1_0_0_0_0_0_0_01_00_00_00;
  localparam logic [17:0] O_FETCH_R = 18'b1_0_0_1_0_1_0_0_0_0_01_00_00_00;
  localparam logic [17:0] O_DECODE  = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_00;
  localparam logic [17:0] O_MEMADR  = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_00;
  localparam logic [17:0] O_MEMRD   = 18'b0_0_1_1_0_0_0_0_0_0_00_00_00_00;
  localparam logic [17:0] O_MEMWB   = 18'b0_0_0_0_0_0_1_0_1_0_00_00_00_00;
  localparam logic [17:0] O_MEMWR   = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_00;
  localparam logic [17:0] O_EXEC    = 18'b0_0_0_0_0_0_0_0_0_1_00_10_00_00;
  localparam logic [17:0] O_RWB     = 18'b0_0_0_0_0_0_0_1_1_0_00_00_00_00;
  localparam logic [17:0] O_BRANCH  = 18'b0_1_0_0_0_0_0_0_0_1_00_01_01_00;
  localparam logic [17:0] O_JUMP    = 18'b1_0_0_0_0_0_0_0_0_0_00_00_10_00;
  localparam logic [17:0] O_IEX_ADD = 18'b0_0_0_0_0_0_0_0_0_1_10_11_00_00;
  localparam logic [17:0] O_IEX_AND = 18'b0_0_0_0_0_0_0_0_0_1_10_11_00_01;
  localparam logic [17:0] O_IEX_OR  = 18'b0_0_0_0_0_0_0_0_0_1_10_11_00_10;
  localparam logic [17:0] O_IWB_ADD = 18'b0_0_0_0_0_0_0_0_1_0_00_00_00_00;
  localparam logic [17:0] O_IWB_AND = 18'b0_0_0_0_0_0_0_0_1_0_00_00_00_01;
  localparam logic [17:0] O_IWB_OR  = 18'b0_0_0_0_0_0_0_0_1_0_00_00_00_10;

  typedef struct {
    logic [5:0]  op;
    logic        rdy;
    logic [3:0]  st;
    logic [17:0] out;
  } vecT;

  vecT vecs[$];

  task automatic add(input logic [5:0] op, input logic rdy, input logic [3:0] st, input logic [17:0] out);
    vecT v;
    v.op = op; v.rdy = rdy; v.st = st; v.out = out;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic releaseReset();
    @(negedge clk);
    reset = 1'b1;
    #1;
  endtask

  task automatic assertReset();
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // R-type
    add(6'b000000, 1'b1, 4'd0,  O_FETCH_R);
    add(6'b000000, 1'b1, 4'd1,  O_DECODE);
    add(6'b000000, 1'b1, 4'd6,  O_EXEC);
    add(6'b000000, 1'b1, 4'd7,  O_RWB);
    // lw with three wait cycles in MEMRD
    add(6'b100011, 1'b1, 4'd0,  O_FETCH_R);
    add(6'b100011, 1'b1, 4'd1,  O_DECODE);
    add(6'b100011, 1'b1, 4'd2,  O_MEMADR);
    add(6'b100011, 1'b0, 4'd3,  O_MEMRD);
    add(6'b100011, 1'b0, 4'd3,  O_MEMRD);
    add(6'b100011, 1'b0, 4'd3,  O_MEMRD);
    add(6'b100011, 1'b1, 4'd3,  O_MEMRD);
    add(6'b100011, 1'b1, 4'd4,  O_MEMWB);
    // sw with one wait cycle
    add(6'b101011, 1'b1, 4'd0,  O_FETCH_R);
    add(6'b101011, 1'b1, 4'd1,  O_DECODE);
    add(6'b101011, 1'b1, 4'd2,  O_MEMADR);
    add(6'b101011, 1'b0, 4'd5,  O_MEMWR);
    add(6'b101011, 1'b1, 4'd5,  O_MEMWR);
    // beq, j
    add(6'b000100, 1'b1, 4'd0,  O_FETCH_R);
    add(6'b000100, 1'b1, 4'd1,  O_DECODE);
    add(6'b000100, 1'b1, 4'd8,  O_BRANCH);
    add(6'b000010, 1'b1, 4'd0,  O_FETCH_R);
    add(6'b000010, 1'b1, 4'd1,  O_DECODE);
    add(6'b000010, 1'b1, 4'd9,  O_JUMP);
    // addi, andi, ori (fetch of the first one waits a cycle)
    add(6'b001000, 1'b0, 4'd0,  O_FETCH_W);
    add(6'b001000, 1'b1, 4'd0,  O_FETCH_R);
    add(6'b001000, 1'b1, 4'd1,  O_DECODE);
    add(6'b001000, 1'b1, 4'd10, O_IEX_ADD);
    add(6'b001000, 1'b1, 4'd11, O_IWB_ADD);
    add(6'b001100, 1'b1, 4'd0,  O_FETCH_R);
    add(6'b001100, 1'b1, 4'd1,  O_DECODE);
    add(6'b001100, 1'b1, 4'd10, O_IEX_AND);
    add(6'b001100, 1'b1, 4'd11, O_IWB_AND);
    add(6'b001101, 1'b1, 4'd0,  O_FETCH_R);
    add(6'b001101, 1'b1, 4'd1,  O_DECODE);
    add(6'b001101, 1'b1, 4'd10, O_IEX_OR);
    add(6'b001101, 1'b1, 4'd11, O_IWB_OR);
    add(6'b000000, 1'b0, 4'd0,  O_FETCH_W);

    // Reset asserted: FETCH state code but every strobe low
    #2;
    chk("reset_state", 32'(bus0.state), 32'd0);
    chk("reset_outs", 32'(outs0), 32'(O_ZERO));
    chk("reset_flags", {30'd0, bus0.illegal, bus0.timeout}, 32'd0);

    // First cycle after release shows normal FETCH outputs
    releaseReset();
    chk("post_reset_fetch", 32'(outs0), 32'(O_FETCH_W));

    foreach (vecs[i]) begin
      if (i != 0) @(negedge clk);
      instr    = {vecs[i].op, 26'h0};
      memReady = vecs[i].rdy;
      #1;
      chk($sformatf("vec%0d_state", i), 32'(bus0.state), 32'(vecs[i].st));
      chk($sformatf("vec%0d_outs", i), 32'(outs0), 32'(vecs[i].out));
      chk($sformatf("vec%0d_flags", i), {30'd0, bus0.illegal, bus0.timeout}, 32'd0);
    end

    // Illegal opcode: trap variant halts, non-trap variant returns to FETCH
    assertReset();
    releaseReset();
    instr    = {6'b111111, 26'h0};
    memReady = 1'b1;
    @(negedge clk);
    chk("illegal_decode", 32'(bus0.state), 32'd1);
    memReady = 1'b0;
    @(negedge clk);
    chk("illegal_trap_state", 32'(bus0.state), 32'd12);
    chk("illegal_flag", 32'(bus0.illegal), 32'd1);
    chk("illegal_notrap_state", 32'(bus1.state), 32'd0);
    chk("illegal_notrap_flag", 32'(bus1.illegal), 32'd0);
    repeat (22) @(negedge clk);
    chk("illegal_hold_state", 32'(bus0.state), 32'd12);
    chk("illegal_hold_flag", 32'(bus0.illegal), 32'd1);
    chk("illegal_hold_outs", 32'(outs0), 32'(O_ZERO));
    chk("illegal_no_timeout", 32'(bus0.timeout), 32'd0);
    #2;
    reset = 1'b0;
    #1;
    chk("illegal_async_clear", 32'(bus0.illegal), 32'd0);
    chk("illegal_async_state", 32'(bus0.state), 32'd0);

    // Timeout: 15 FETCH cycles without mem_ready, then TRAP
    instr    = 32'd0;
    memReady = 1'b0;
    releaseReset();
    chk("to_fetch_c1", 32'(bus0.state), 32'd0);
    for (int k = 2; k <= 15; k++) begin
      @(negedge clk);
      chk($sformatf("to_fetch_c%0d", k), 32'(bus0.state), 32'd0);
    end
    @(negedge clk);
    chk("to_trap_state", 32'(bus0.state), 32'd12);
    chk("to_flag", 32'(bus0.timeout), 32'd1);
    chk("to_no_illegal", 32'(bus0.illegal), 32'd0);
    chk("to_trap_outs", 32'(outs0), 32'(O_ZERO));
    repeat (40) @(negedge clk);
    chk("to_hold_state", 32'(bus0.state), 32'd12);
    chk("to_hold_flag", 32'(bus0.timeout), 32'd1);
    chk("to_disabled_state", 32'(bus2.state), 32'd0);
    chk("to_disabled_flag", 32'(bus2.timeout), 32'd0);

    // mem_ready on the last allowed wait cycle wins over the timeout
    assertReset();
    releaseReset();
    repeat (14) @(negedge clk);
    chk("to_edge_still_fetch", 32'(bus0.state), 32'd0);
    memReady = 1'b1;
    @(negedge clk);
    chk("to_edge_ready_state", 32'(bus0.state), 32'd1);
    chk("to_edge_ready_flag", 32'(bus0.timeout), 32'd0);

    // Reset in MEMWR drops MemWrite with no clock edge
    assertReset();
    instr    = {6'b101011, 26'h0};
    memReady = 1'b1;
    releaseReset();
    repeat (3) @(negedge clk);
    memReady = 1'b0;
    #1;
    chk("memwr_state", 32'(bus0.state), 32'd5);
    chk("memwr_strobe", 32'(bus0.MemWrite), 32'd1);
    reset = 1'b0;
    #1;
    chk("memwr_async_strobe", 32'(bus0.MemWrite), 32'd0);
    chk("memwr_async_state", 32'(bus0.state), 32'd0);
    chk("memwr_async_outs", 32'(outs0), 32'(O_ZERO));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
